// File: rtl/bin_bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin_bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter used on the
// DIG (7-seg) MMIO path: FSM state encoding, BCD digit width and the
// double-dabble correction constants.
// No ports (package).
// -----------------------------------------------------------------------------
package bin_bcd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Bits per BCD digit.
  localparam int BCD_W = 4;

  // Double-dabble: a digit >= 5 gets +3 before the shift so that the doubled
  // value carries correctly into the next decade.
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_OFFSET = 4'd3;

endpackage : bin_bcd_pkg

// File: rtl/bin_bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin_bcd_seq_if
// Bus bundle between the MMIO controller / display scanner and the
// binary-to-BCD converter.
//   digcs, digwrite : qualified write (both high) starts a conversion
//   mode_signed     : treat binary as two's complement
//   binary          : value to convert
//   decimal         : BCD result, digit 0 in bits [3:0]
//   neg, ovf        : sign and overflow of the result
//   busy, done      : conversion running / one-cycle result-updated pulse
// Modports: master = controller side, slave = converter side.
// -----------------------------------------------------------------------------
interface bin_bcd_seq_if
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);

  logic                      digcs;
  logic                      digwrite;
  logic                      mode_signed;
  logic [BIN_W-1:0]          binary;
  logic [BCD_W*DIGITS-1:0]   decimal;
  logic                      neg;
  logic                      ovf;
  logic                      busy;
  logic                      done;

  modport master (
    output digcs, digwrite, mode_signed, binary,
    input  decimal, neg, ovf, busy, done
  );

  modport slave (
    input  digcs, digwrite, mode_signed, binary,
    output decimal, neg, ovf, busy, done
  );

endinterface : bin_bcd_seq_if

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Per-digit double-dabble correction: passes the digit through unchanged
// unless it is 5 or more, in which case 3 is added (4-bit result).
//   din  : working BCD digit
//   dout : corrected digit, ready to be shifted left
// -----------------------------------------------------------------------------
module bcd_digit_adj
  import bin_bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add-3 correction for digits that would exceed 9 after doubling.
  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) begin
      dout = din + ADJ_OFFSET;
    end else begin
      dout = din;
    end
  end

endmodule : bcd_digit_adj

// File: rtl/bin_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_bcd_seq
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// A conversion starts on digcs && digwrite while not busy; the result,
// sign and overflow are registered when the last bit has been shifted in
// and held until the next conversion completes.
//   clock   : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : bin_bcd_seq_if.slave (write strobe, operands, results, handshake)
// -----------------------------------------------------------------------------
module bin_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
)(
  input  logic          clock,
  input  logic          reset_n,
  bin_bcd_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DEC_W = BCD_W * DIGITS;

  state_t               state_r;
  state_t               state_nx_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [BIN_W-1:0]     shreg_r;
  logic [DEC_W-1:0]     dig_r;
  logic                 sign_r;
  logic                 wovf_r;
  logic [DEC_W-1:0]     decimal_r;
  logic                 neg_r;
  logic                 ovf_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 accept_s;
  logic                 last_s;
  logic                 neg_in_s;
  logic [BIN_W-1:0]     mag_s;
  logic [DEC_W-1:0]     adj_s;
  logic [DEC_W-1:0]     dig_nx_s;
  logic                 carry_s;
  logic                 load_s;
  logic                 shift_s;
  logic                 commit_s;
  logic                 busy_nx_s;
  logic                 done_nx_s;

  // Correction stage: one add-3 cell per working digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (dig_r[g*BCD_W +: BCD_W]),
      .dout (adj_s[g*BCD_W +: BCD_W])
    );
  end

  // Write qualification, operand magnitude and the shifted digit vector.
  always_comb begin
    accept_s = 1'b0;
    neg_in_s = 1'b0;
    mag_s    = bus.binary;
    if (bus.digcs && bus.digwrite && (state_r != ST_SHIFT)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    // Negation is done in BIN_W bits; the most-negative value maps onto
    // itself, which read unsigned is exactly its magnitude.
    if (bus.mode_signed && bus.binary[BIN_W-1]) begin
      neg_in_s = 1'b1;
      mag_s    = (~bus.binary) + BIN_W'(1);
    end else begin
      neg_in_s = 1'b0;
      mag_s    = bus.binary;
    end
    dig_nx_s = {adj_s[DEC_W-2:0], shreg_r[BIN_W-1]};
    carry_s  = adj_s[DEC_W-1];
    last_s   = (cnt_r == CNT_W'(1));
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_SHIFT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (accept_s) begin
          state_nx_s = ST_SHIFT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Output/control decode; busy/done are decoded from the next state so the
  // registered copies line up with the state register.
  always_comb begin
    load_s    = 1'b0;
    shift_s   = 1'b0;
    commit_s  = 1'b0;
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        load_s = accept_s;
      end
      ST_SHIFT: begin
        shift_s  = 1'b1;
        commit_s = last_s;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
    case (state_nx_s)
      ST_SHIFT: begin
        busy_nx_s = 1'b1;
      end
      ST_DONE: begin
        done_nx_s = 1'b1;
      end
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
  end

  // Datapath: operand load, shift/correct, and result commit on DONE entry.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      shreg_r   <= {BIN_W{1'b0}};
      dig_r     <= {DEC_W{1'b0}};
      sign_r    <= 1'b0;
      wovf_r    <= 1'b0;
      decimal_r <= {DEC_W{1'b0}};
      neg_r     <= 1'b0;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      if (load_s) begin
        shreg_r <= mag_s;
        sign_r  <= neg_in_s;
        dig_r   <= {DEC_W{1'b0}};
        wovf_r  <= 1'b0;
        cnt_r   <= CNT_W'(BIN_W);
      end else if (shift_s) begin
        shreg_r <= {shreg_r[BIN_W-2:0], 1'b0};
        dig_r   <= dig_nx_s;
        // A 1 leaving the top digit means the value needs another decade.
        wovf_r  <= wovf_r | carry_s;
        cnt_r   <= cnt_r - CNT_W'(1);
      end
      if (commit_s) begin
        decimal_r <= dig_nx_s;
        neg_r     <= sign_r;
        ovf_r     <= wovf_r | carry_s;
      end
      busy_r <= busy_nx_s;
      done_r <= done_nx_s;
    end
  end

  assign bus.decimal = decimal_r;
  assign bus.neg     = neg_r;
  assign bus.ovf     = ovf_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule : bin_bcd_seq

// File: tb/tb_bin_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_bcd_seq
// Scoreboard bench for bin_bcd_seq: a default instance (16-bit, 5 digits)
// and a 4-digit instance share clock and reset. Expected results come from
// an integer reference model and are compared when done pulses.
// -----------------------------------------------------------------------------
module tb_bin_bcd_seq;

  typedef struct packed {
    logic [39:0] dec;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic clock;
  logic reset_n;

  int checks;
  int failures;

  exp_t sb_a[$];
  exp_t sb_b[$];

  bin_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) ifa ();
  bin_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) ifb ();

  bin_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifa.slave)
  );

  bin_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifb.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] b, input bit sgn, input int digits);
    exp_t        e;
    int unsigned mag;
    int unsigned lim;
    e.dec = 40'd0;
    e.neg = sgn && b[15];
    mag   = e.neg ? (32'd65536 - {16'd0, b}) : {16'd0, b};
    lim   = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    for (int i = 0; i < digits; i++) begin
      e.dec[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return e;
  endfunction

  // Scoreboard compare for the 5-digit instance.
  always @(negedge clock) begin
    if (ifa.done === 1'b1) begin
      check_val("a_done_expected", 64'(sb_a.size() != 0), 64'd1);
      if (sb_a.size() != 0) begin
        exp_t e;
        e = sb_a.pop_front();
        check_val("a_decimal", 64'(ifa.decimal), 64'(e.dec[19:0]));
        check_val("a_neg", 64'(ifa.neg), 64'(e.neg));
        check_val("a_ovf", 64'(ifa.ovf), 64'(e.ovf));
      end
    end
  end

  // Scoreboard compare for the 4-digit instance.
  always @(negedge clock) begin
    if (ifb.done === 1'b1) begin
      check_val("b_done_expected", 64'(sb_b.size() != 0), 64'd1);
      if (sb_b.size() != 0) begin
        exp_t e;
        e = sb_b.pop_front();
        check_val("b_decimal", 64'(ifb.decimal), 64'(e.dec[15:0]));
        check_val("b_neg", 64'(ifb.neg), 64'(e.neg));
        check_val("b_ovf", 64'(ifb.ovf), 64'(e.ovf));
      end
    end
  end

  // Drive one write cycle; push the model result when it should be accepted.
  task automatic write_in(input int which, input logic [15:0] val, input bit sgn, input bit push);
    if (which == 0) begin
      ifa.digcs = 1'b1; ifa.digwrite = 1'b1; ifa.binary = val; ifa.mode_signed = sgn;
      if (push) sb_a.push_back(model(val, sgn, 5));
    end else begin
      ifb.digcs = 1'b1; ifb.digwrite = 1'b1; ifb.binary = val; ifb.mode_signed = sgn;
      if (push) sb_b.push_back(model(val, sgn, 4));
    end
    @(posedge clock);
    #1;
    ifa.digcs = 1'b0; ifa.digwrite = 1'b0;
    ifb.digcs = 1'b0; ifb.digwrite = 1'b0;
  endtask

  // Wait (bounded) for done; returns cycles seen and how many were busy.
  task automatic wait_done(input int which, output int n, output int busy_n);
    bit seen;
    seen   = 1'b0;
    n      = 0;
    busy_n = 0;
    while (!seen && n < 100) begin
      @(negedge clock);
      n++;
      if (which == 0) begin
        if (ifa.busy === 1'b1) busy_n++;
        if (ifa.done === 1'b1) seen = 1'b1;
      end else begin
        if (ifb.busy === 1'b1) busy_n++;
        if (ifb.done === 1'b1) seen = 1'b1;
      end
    end
    check_val(which == 0 ? "a_done_seen" : "b_done_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    int n;
    int bn;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    ifa.digcs = 1'b0; ifa.digwrite = 1'b0; ifa.mode_signed = 1'b0; ifa.binary = 16'd0;
    ifb.digcs = 1'b0; ifb.digwrite = 1'b0; ifb.mode_signed = 1'b0; ifb.binary = 16'd0;
    repeat (3) @(negedge clock);

    check_val("rst_decimal", 64'(ifa.decimal), 64'd0);
    check_val("rst_neg", 64'(ifa.neg), 64'd0);
    check_val("rst_ovf", 64'(ifa.ovf), 64'd0);
    check_val("rst_busy", 64'(ifa.busy), 64'd0);
    check_val("rst_done", 64'(ifa.done), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Unsigned full-scale with latency and busy length.
    write_in(0, 16'd65535, 1'b0, 1'b1);
    wait_done(0, n, bn);
    check_val("lat_done_cycle", 64'(n), 64'd17);
    check_val("lat_busy_cycles", 64'(bn), 64'd16);

    // Signed cases: -1, most negative, zero.
    write_in(0, 16'hFFFF, 1'b1, 1'b1);
    wait_done(0, n, bn);
    write_in(0, 16'h8000, 1'b1, 1'b1);
    wait_done(0, n, bn);
    write_in(0, 16'd0, 1'b1, 1'b1);
    wait_done(0, n, bn);

    // Four-digit instance: overflow then largest representable.
    write_in(1, 16'd12345, 1'b0, 1'b1);
    wait_done(1, n, bn);
    write_in(1, 16'd9999, 1'b0, 1'b1);
    wait_done(1, n, bn);

    // Random operands in both modes.
    for (int i = 0; i < 6; i++) begin
      write_in(0, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b1);
      wait_done(0, n, bn);
    end

    // Write while busy is ignored; write during DONE is accepted.
    write_in(0, 16'd100, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    write_in(0, 16'd7, 1'b0, 1'b0);
    wait_done(0, n, bn);
    write_in(0, 16'd7, 1'b0, 1'b1);
    wait_done(0, n, bn);
    check_val("done_to_done", 64'(n), 64'd17);

    // Reset mid-conversion aborts with no done pulse.
    write_in(0, 16'd4321, 1'b0, 1'b0);
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_val("abort_decimal", 64'(ifa.decimal), 64'd0);
    check_val("abort_busy", 64'(ifa.busy), 64'd0);
    check_val("abort_done", 64'(ifa.done), 64'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    write_in(0, 16'd42, 1'b0, 1'b1);
    wait_done(0, n, bn);
    @(negedge clock);

    // Half-qualified writes start nothing.
    ifa.binary = 16'd999;
    ifa.digcs = 1'b1; ifa.digwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val("cs_only_busy", 64'(ifa.busy), 64'd0);
      check_val("cs_only_decimal", 64'(ifa.decimal), 64'h00042);
    end
    ifa.digcs = 1'b0; ifa.digwrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val("wr_only_busy", 64'(ifa.busy), 64'd0);
      check_val("wr_only_decimal", 64'(ifa.decimal), 64'h00042);
    end
    ifa.digwrite = 1'b0;
    repeat (20) @(negedge clock);

    check_val("sb_a_drained", 64'(sb_a.size()), 64'd0);
    check_val("sb_b_drained", 64'(sb_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bin_bcd_seq
